// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32I core: stall/flush enables,
// E-stage forwarding selects, post-reset halt, memory freeze and perf counters.
module hazard_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32,
  parameter logic [1:0]  LOAD_SRC    = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_i,
  input  logic [4:0]       Rs1D_i,
  input  logic [4:0]       Rs2D_i,
  input  logic             Rs1UsedD_i,
  input  logic             Rs2UsedD_i,
  input  logic [4:0]       Rs1E_i,
  input  logic [4:0]       Rs2E_i,
  input  logic [4:0]       RdE_i,
  input  logic             RegWriteE_i,
  input  logic [1:0]       ResultSrcE_i,
  input  logic [1:0]       PCSrcE_i,
  input  logic [4:0]       RdM_i,
  input  logic [4:0]       RdW_i,
  input  logic             RegWriteM_i,
  input  logic             RegWriteW_i,
  input  logic             MemReqM_i,
  input  logic             MemReadyM_i,
  output logic             StallF_o,
  output logic             StallD_o,
  output logic             StallE_o,
  output logic             StallM_o,
  output logic             FlushD_o,
  output logic             FlushE_o,
  output logic             FlushW_o,
  output logic [1:0]       ForwardAE_o,
  output logic [1:0]       ForwardBE_o,
  output logic [CNT_W-1:0] StallCnt_o,
  output logic [CNT_W-1:0] FlushCnt_o,
  output logic             MemErr_o
);

  localparam int unsigned       WAIT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {HALT, RUN, MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic              freeze, redirect, load_use, redirect_act;

  // Once in MEM_WAIT the freeze lasts until ready, independent of the request line.
  assign freeze   = ~MemReadyM_i &
                    (((state_q == RUN) & MemReqM_i) | (state_q == MEM_WAIT));
  assign redirect = (PCSrcE_i != 2'b00);
  assign load_use = (ResultSrcE_i == LOAD_SRC) & RegWriteE_i & (RdE_i != 5'd0) &
                    ((Rs1UsedD_i & (RdE_i == Rs1D_i)) | (Rs2UsedD_i & (RdE_i == Rs2D_i)));

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (RegWriteM_i && (RdM_i != 5'd0) && (RdM_i == rs)) return 2'b10;
    if (RegWriteW_i && (RdW_i != 5'd0) && (RdW_i == rs)) return 2'b01;
    return 2'b00;
  endfunction

  assign ForwardAE_o = fwd_sel(Rs1E_i);
  assign ForwardBE_o = fwd_sel(Rs2E_i);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    mem_err_d    = mem_err_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    StallF_o     = 1'b0;
    StallD_o     = 1'b0;
    StallE_o     = 1'b0;
    StallM_o     = 1'b0;
    FlushD_o     = 1'b0;
    FlushE_o     = 1'b0;
    FlushW_o     = 1'b0;
    redirect_act = 1'b0;

    unique case (state_q)
      HALT: begin
        StallF_o = 1'b1;
        FlushD_o = 1'b1;
        FlushE_o = 1'b1;
        if (trigger_i) state_d = RUN;
      end
      RUN: begin
        if (MemReqM_i && !MemReadyM_i) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (MemReadyM_i) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          if (wait_q != WAIT_MAX) wait_d = wait_q + 1'b1;
          if (wait_d == WAIT_MAX) mem_err_d = 1'b1;
        end
      end
      default: state_d = HALT;
    endcase

    // The ready cycle of a wait already advances the pipeline, so a redirect or
    // load-use sitting in E/D must be honoured there rather than slip past.
    if (state_q != HALT) begin
      if (freeze) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        StallE_o = 1'b1;
        StallM_o = 1'b1;
        FlushW_o = 1'b1;
      end else if (redirect) begin
        FlushD_o     = 1'b1;
        FlushE_o     = 1'b1;
        redirect_act = 1'b1;
      end else if (load_use) begin
        StallF_o = 1'b1;
        StallD_o = 1'b1;
        FlushE_o = 1'b1;
      end
      if (StallF_o && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + 1'b1;
      if (redirect_act && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= HALT;
      wait_q      <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign StallCnt_o = stall_cnt_q;
  assign FlushCnt_o = flush_cnt_q;
  assign MemErr_o   = mem_err_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed sequences, a forwarding vector
// table, and random stimulus against a rule-level reference model.
module tb_hazard_ctrl;
  localparam int TO = 4;
  localparam int CW = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  localparam logic [6:0] C_IDLE   = 7'b0000000; // {SF,SD,SE,SM,FD,FE,FW}
  localparam logic [6:0] C_HALT   = 7'b1000110;
  localparam logic [6:0] C_FREEZE = 7'b1111001;
  localparam logic [6:0] C_REDIR  = 7'b0000110;
  localparam logic [6:0] C_LU     = 7'b1100010;

  logic clk = 1'b0;
  logic rst;
  logic trigger_i;
  logic [4:0] Rs1D_i, Rs2D_i, Rs1E_i, Rs2E_i, RdE_i, RdM_i, RdW_i;
  logic Rs1UsedD_i, Rs2UsedD_i, RegWriteE_i, RegWriteM_i, RegWriteW_i;
  logic [1:0] ResultSrcE_i, PCSrcE_i;
  logic MemReqM_i, MemReadyM_i;
  logic StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o;
  logic [1:0] ForwardAE_o, ForwardBE_o;
  logic [CW-1:0] StallCnt_o, FlushCnt_o;
  logic MemErr_o;

  hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW), .LOAD_SRC(2'b01)) dut (
    .clk(clk), .rst(rst), .trigger_i(trigger_i),
    .Rs1D_i(Rs1D_i), .Rs2D_i(Rs2D_i), .Rs1UsedD_i(Rs1UsedD_i), .Rs2UsedD_i(Rs2UsedD_i),
    .Rs1E_i(Rs1E_i), .Rs2E_i(Rs2E_i), .RdE_i(RdE_i), .RegWriteE_i(RegWriteE_i),
    .ResultSrcE_i(ResultSrcE_i), .PCSrcE_i(PCSrcE_i),
    .RdM_i(RdM_i), .RdW_i(RdW_i), .RegWriteM_i(RegWriteM_i), .RegWriteW_i(RegWriteW_i),
    .MemReqM_i(MemReqM_i), .MemReadyM_i(MemReadyM_i),
    .StallF_o(StallF_o), .StallD_o(StallD_o), .StallE_o(StallE_o), .StallM_o(StallM_o),
    .FlushD_o(FlushD_o), .FlushE_o(FlushE_o), .FlushW_o(FlushW_o),
    .ForwardAE_o(ForwardAE_o), .ForwardBE_o(ForwardBE_o),
    .StallCnt_o(StallCnt_o), .FlushCnt_o(FlushCnt_o), .MemErr_o(MemErr_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: halted?, inside a memory wait?, wait cycles seen.
  bit m_halt, m_wait, m_err;
  int m_wcnt, m_scnt, m_fcnt;

  typedef struct {
    logic [4:0] rs1e, rs2e, rdm, rdw;
    logic       wm, ww;
    logic [1:0] expa, expb;
  } fwd_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] ctrl_now();
    return {StallF_o, StallD_o, StallE_o, StallM_o, FlushD_o, FlushE_o, FlushW_o};
  endfunction

  function automatic bit m_freeze();
    return !m_halt && !MemReadyM_i && (m_wait || MemReqM_i);
  endfunction

  function automatic bit m_loaduse();
    return ResultSrcE_i == 2'b01 && RegWriteE_i && RdE_i != 0 &&
           ((Rs1UsedD_i && RdE_i == Rs1D_i) || (Rs2UsedD_i && RdE_i == Rs2D_i));
  endfunction

  function automatic logic [6:0] m_ctrl();
    if (m_halt) return C_HALT;
    if (m_freeze()) return C_FREEZE;
    if (PCSrcE_i != 0) return C_REDIR;
    if (m_loaduse()) return C_LU;
    return C_IDLE;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [4:0] rs);
    if (rs != 0 && RegWriteM_i && RdM_i == rs) return 2'b10;
    if (rs != 0 && RegWriteW_i && RdW_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    m_halt = 1; m_wait = 0; m_err = 0; m_wcnt = 0; m_scnt = 0; m_fcnt = 0;
  endtask

  // Advance the model across one rising edge using the inputs now applied.
  task automatic model_step();
    logic [6:0] c;
    if (!rst) begin model_reset(); return; end
    c = m_ctrl();
    if (m_halt) begin
      if (trigger_i) m_halt = 0;
      return;
    end
    if (c[6] && m_scnt < CNT_MAX) m_scnt++;
    if (c == C_REDIR && m_fcnt < CNT_MAX) m_fcnt++;
    if (m_freeze()) begin
      if (m_wait) begin
        m_wcnt = (m_wcnt < TO) ? m_wcnt + 1 : TO;
        if (m_wcnt >= TO) m_err = 1;
      end
      m_wait = 1;
    end else begin
      m_wait = 0;
      m_wcnt = 0;
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ctrl"}, 32'(ctrl_now()), 32'(m_ctrl()));
    chk({tag, "_fwdA"}, 32'(ForwardAE_o), 32'(m_fwd(Rs1E_i)));
    chk({tag, "_fwdB"}, 32'(ForwardBE_o), 32'(m_fwd(Rs2E_i)));
    chk({tag, "_scnt"}, 32'(StallCnt_o), 32'(m_scnt));
    chk({tag, "_fcnt"}, 32'(FlushCnt_o), 32'(m_fcnt));
    chk({tag, "_err"},  32'(MemErr_o),   32'(m_err));
  endtask

  // Inputs are applied just after an edge; check, then cross the next edge.
  task automatic cycle(input string tag);
    #2;
    check_model(tag);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    trigger_i = 0; Rs1D_i = 0; Rs2D_i = 0; Rs1UsedD_i = 0; Rs2UsedD_i = 0;
    Rs1E_i = 0; Rs2E_i = 0; RdE_i = 0; RegWriteE_i = 0; ResultSrcE_i = 0; PCSrcE_i = 0;
    RdM_i = 0; RdW_i = 0; RegWriteM_i = 0; RegWriteW_i = 0; MemReqM_i = 0; MemReadyM_i = 1;
  endtask

  task automatic start_run();
    trigger_i = 1;
    cycle("trig");
    trigger_i = 0;
  endtask

  task automatic set_loaduse(input logic [4:0] rd);
    ResultSrcE_i = 2'b01; RegWriteE_i = 1; RdE_i = rd; Rs1D_i = 5; Rs1UsedD_i = 1;
  endtask

  fwd_vec_t fv[8];

  initial begin
    clear_inputs();
    rst = 0;
    model_reset();
    @(posedge clk); #1;

    // Held in reset, then halted until trigger.
    for (int i = 0; i < 5; i++) begin
      #1 chk("reset_halt_ctrl", 32'(ctrl_now()), 32'(C_HALT));
      chk("reset_scnt", 32'(StallCnt_o), 0);
      cycle("reset");
    end
    rst = 1;
    cycle("halt_idle");
    #1 chk("halt_ctrl", 32'(ctrl_now()), 32'(C_HALT));
    start_run();
    #1 chk("run_idle_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    cycle("run_idle");

    // Load-use stall, then the same with x0 destination.
    set_loaduse(5);
    #1 chk("loaduse_ctrl", 32'(ctrl_now()), 32'(C_LU));
    cycle("loaduse");
    RdE_i = 0;
    #1 chk("loaduse_x0_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    chk("loaduse_scnt", 32'(StallCnt_o), 1);
    cycle("loaduse_x0");

    // Redirect wins over a coincident load-use.
    set_loaduse(5); PCSrcE_i = 2'b01;
    #1 chk("redir_lu_ctrl", 32'(ctrl_now()), 32'(C_REDIR));
    cycle("redir_lu");
    clear_inputs();
    #1 chk("redir_fcnt", 32'(FlushCnt_o), 1);
    chk("redir_scnt", 32'(StallCnt_o), 1);

    // Three-cycle memory freeze with a held redirect, acted on at release.
    MemReqM_i = 1; MemReadyM_i = 0; PCSrcE_i = 2'b10;
    for (int i = 0; i < 3; i++) begin
      #1 chk("freeze_ctrl", 32'(ctrl_now()), 32'(C_FREEZE));
      cycle("freeze");
    end
    MemReadyM_i = 1;
    #1 chk("release_ctrl", 32'(ctrl_now()), 32'(C_REDIR));
    cycle("release");
    clear_inputs();
    #1 chk("freeze_scnt", 32'(StallCnt_o), 4);
    chk("freeze_fcnt", 32'(FlushCnt_o), 2);
    chk("freeze_err", 32'(MemErr_o), 0);
    cycle("post_freeze");

    // Timeout: flag appears after the fourth wait-state cycle and is sticky.
    MemReqM_i = 1; MemReadyM_i = 0;
    for (int i = 1; i <= 6; i++) begin
      #1 chk("timeout_err", 32'(MemErr_o), (i == 6) ? 1 : 0);
      cycle("timeout");
    end
    MemReadyM_i = 1;
    cycle("timeout_rel");
    clear_inputs();
    #1 chk("sticky_err", 32'(MemErr_o), 1);
    cycle("sticky");

    // Asynchronous reset in the middle of a wait.
    MemReqM_i = 1; MemReadyM_i = 0;
    cycle("wait_a"); cycle("wait_b");
    #2 rst = 0;
    #1 chk("areset_ctrl", 32'(ctrl_now()), 32'(C_HALT));
    chk("areset_err", 32'(MemErr_o), 0);
    chk("areset_scnt", 32'(StallCnt_o), 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1; clear_inputs();
    start_run();

    // Forwarding vectors.
    fv[0] = '{7, 7, 7, 7, 1, 1, 2'b10, 2'b10};
    fv[1] = '{7, 7, 7, 7, 0, 1, 2'b01, 2'b01};
    fv[2] = '{7, 7, 7, 0, 0, 1, 2'b00, 2'b00};
    fv[3] = '{7, 3, 3, 7, 1, 1, 2'b01, 2'b10};
    fv[4] = '{0, 0, 0, 0, 1, 1, 2'b00, 2'b00};
    fv[5] = '{9, 4, 9, 4, 1, 0, 2'b10, 2'b00};
    fv[6] = '{31, 31, 30, 31, 1, 1, 2'b01, 2'b01};
    fv[7] = '{12, 12, 12, 12, 0, 0, 2'b00, 2'b00};
    foreach (fv[i]) begin
      Rs1E_i = fv[i].rs1e; Rs2E_i = fv[i].rs2e; RdM_i = fv[i].rdm; RdW_i = fv[i].rdw;
      RegWriteM_i = fv[i].wm; RegWriteW_i = fv[i].ww;
      #1 chk($sformatf("fwdA_vec%0d", i), 32'(ForwardAE_o), 32'(fv[i].expa));
      chk($sformatf("fwdB_vec%0d", i), 32'(ForwardBE_o), 32'(fv[i].expb));
      cycle("fwd");
    end
    clear_inputs();

    // Long freeze to saturate the stall counter.
    MemReqM_i = 1; MemReadyM_i = 0;
    for (int i = 0; i < CNT_MAX + 5; i++) cycle("saturate");
    #1 chk("sat_scnt", 32'(StallCnt_o), CNT_MAX);
    clear_inputs();
    cycle("sat_rel");

    // Random stimulus against the model.
    for (int n = 0; n < 4000; n++) begin
      trigger_i    = ($urandom_range(0, 19) == 0);
      Rs1D_i       = 5'($urandom_range(0, 3));
      Rs2D_i       = 5'($urandom_range(0, 3));
      Rs1UsedD_i   = 1'($urandom);
      Rs2UsedD_i   = 1'($urandom);
      Rs1E_i       = 5'($urandom_range(0, 3));
      Rs2E_i       = 5'($urandom_range(0, 3));
      RdE_i        = 5'($urandom_range(0, 3));
      RegWriteE_i  = 1'($urandom);
      ResultSrcE_i = 2'($urandom);
      PCSrcE_i     = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      RdM_i        = 5'($urandom_range(0, 3));
      RdW_i        = 5'($urandom_range(0, 3));
      RegWriteM_i  = 1'($urandom);
      RegWriteW_i  = 1'($urandom);
      MemReqM_i    = ($urandom_range(0, 2) == 0);
      MemReadyM_i  = ($urandom_range(0, 9) < 6);
      if (!rst) rst = 1;
      else if ($urandom_range(0, 299) == 0) begin
        rst = 0;
        model_reset();
      end
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32I core (F/D/E/M/W with FD, DE, EM and MW pipeline registers). It generates stall and flush enables for the pipeline registers and the E-stage forwarding selects. It holds the core halted after reset until trigger, and freezes the pipeline while a multi-cycle data memory is busy. It also keeps stall/flush performance counters and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 16, consecutive MEM_WAIT cycles after which MemErr_o is set (≥1)
CNT_W, 32, width of the performance counters
LOAD_SRC, 2'b01, ResultSrc encoding that marks a load

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
trigger_i  in  1  start; releases HALT
Rs1D_i, Rs2D_i  in  5 each  D-stage source registers
Rs1UsedD_i, Rs2UsedD_i  in  1 each  D-stage instruction actually reads Rs1/Rs2
Rs1E_i, Rs2E_i  in  5 each  E-stage source registers
RdE_i  in  5  E-stage destination
RegWriteE_i  in  1  E-stage writes regfile
ResultSrcE_i  in  2  E-stage result select
PCSrcE_i  in  2  E-stage PC select; nonzero = redirect (taken branch/jump)
RdM_i, RdW_i  in  5 each  M/W destinations
RegWriteM_i, RegWriteW_i  in  1 each  M/W regfile write enables
MemReqM_i  in  1  M-stage load/store active
MemReadyM_i  in  1  data memory completes the access this cycle
StallF_o, StallD_o, StallE_o, StallM_o  out  1 each  hold PC / FD / DE / EM registers
FlushD_o, FlushE_o, FlushW_o  out  1 each  bubble into FD / DE / MW registers
ForwardAE_o, ForwardBE_o  out  2 each  operand select: 00 regfile, 10 from M, 01 from W
StallCnt_o  out  CNT_W  cycles stalled in RUN/MEM_WAIT
FlushCnt_o  out  CNT_W  redirects taken
MemErr_o  out  1  sticky memory timeout

Behaviour:
- FSM states: HALT, RUN, MEM_WAIT. Reset (rst=0, async) forces HALT, counters 0, wait counter 0, MemErr_o 0.
- HALT: StallF=1, FlushD=1, FlushE=1; all other stall/flush 0. Go to RUN on an edge with trigger_i=1. trigger_i is ignored outside HALT.
- RUN→MEM_WAIT when MemReqM_i=1 and MemReadyM_i=0. Same cycle, combinationally: StallF, StallD, StallE, StallM=1; FlushW=1.
- MEM_WAIT: the same freeze outputs are held. The wait counter increments each cycle. Return to RUN on the edge where MemReadyM_i=1; the freeze is deasserted in that same cycle (combinational on ready). MemReqM_i with MemReadyM_i=1 in RUN causes no stall.
- Timeout: the wait counter reaching MEM_TIMEOUT sets MemErr_o (sticky until reset). The FSM keeps waiting; the counter saturates. The counter clears on leaving MEM_WAIT.
- Load-use, in RUN only: ResultSrcE_i==LOAD_SRC, RegWriteE_i=1, RdE_i≠0, and either (Rs1UsedD_i and RdE_i==Rs1D_i) or (Rs2UsedD_i and RdE_i==Rs2D_i). Response: StallF=1, StallD=1, FlushE=1 for exactly that cycle.
- Redirect, in RUN only: PCSrcE_i≠0 gives FlushD=1, FlushE=1, with no stalls.
- Priority: reset > HALT > memory freeze > redirect > load-use.
- Redirect and load-use in the same cycle: only the redirect acts.
- Redirect during a memory freeze is ignored. The E stage is held, so the redirect reappears after the freeze ends.
- Forwarding (combinational, all states):
  - ForwardAE=10 if RegWriteM_i, RdM_i≠0 and RdM_i==Rs1E_i.
  - Otherwise 01 if RegWriteW_i, RdW_i≠0 and RdW_i==Rs1E_i.
  - Otherwise 00.
  - ForwardBE is identical using Rs2E_i. M has priority over W.
- StallCnt_o increments on each cycle with StallF_o=1 while not in HALT.
- FlushCnt_o increments on each acted-on redirect.
- Both counters saturate at all-ones.
- All control outputs are combinational from state and inputs. There are no registered control outputs, so latency is 0.

Test Plan:
- Reset low, trigger_i=0 for 5 cycles → HALT with StallF=FlushD=FlushE=1, counters 0. Pulse trigger_i=1 one cycle → RUN next edge, all stall/flush 0.
- RUN: ResultSrcE=01, RegWriteE=1, RdE=5, Rs1D=5, Rs1UsedD=1 → StallF=StallD=FlushE=1 for one cycle, StallCnt_o=1. Same case with RdE=0 → no stall.
- RUN: PCSrcE=01 and the load-use condition above in the same cycle → FlushD=FlushE=1, StallF=0, FlushCnt_o=1, StallCnt_o unchanged.
- MemReqM=1, MemReadyM=0 for 3 cycles then 1 → freeze (StallF/D/E/M=1, FlushW=1) for 3 cycles, released in the ready cycle, StallCnt_o+=3, MemErr_o=0. PCSrcE=10 held during the freeze → no flush until release.
- MEM_TIMEOUT=4, MemReadyM=0 for 6 cycles → MemErr_o rises after the 4th wait cycle and stays 1 after ready. Async rst low mid-wait → immediate HALT, MemErr_o=0.
- RegWriteM=1, RdM=7; RegWriteW=1, RdW=7; Rs1E=7, Rs2E=7 → ForwardAE=ForwardBE=10. Set RegWriteM=0 → both 01. Set RdW=0 → both 00.
